// File: rtl/memory_interface_dp.sv
// Dual-port simulation memory: port A read-only fetch, port B load/store, fixed LATENCY response pipeline.
// Define MEM_BOUNDS_CHECK_EN to reject out-of-range word indexes instead of wrapping them.
module memory_interface_dp #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WORD_COUNT  = 1 << (ADDR_W - 2),
  parameter int unsigned LATENCY     = 1,
  localparam int unsigned WORD_W      = 32,
  localparam int unsigned MEM_COUNT_W = 2,
  localparam int unsigned MEM_CODE_W  = 2
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   i_a_req_valid,
  input  logic [ADDR_W-1:0]      i_a_req_addr,
  input  logic [MEM_COUNT_W-1:0] i_a_req_count,
  output logic                   o_a_res_valid,
  output logic [WORD_W-1:0]      o_a_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_a_res_code,
  input  logic                   i_b_req_valid,
  input  logic [ADDR_W-1:0]      i_b_req_addr,
  input  logic [WORD_W-1:0]      i_b_req_wr_data,
  input  logic                   i_b_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_b_req_count,
  input  logic                   i_b_req_unsigned,
  output logic                   o_b_res_valid,
  output logic [WORD_W-1:0]      o_b_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_b_res_code
);

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID    = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ       = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE      = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED = 2'd3;

  localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;

  typedef struct packed {
    logic                  valid;
    logic [WORD_W-1:0]     data;
    logic [MEM_CODE_W-1:0] code;
  } res_t;

  localparam res_t RES_IDLE = '{valid: 1'b0, data: '0, code: MEM_CODE_INVALID};

  if (LATENCY == 0 || LATENCY > 8) begin : g_bad_latency
    $error("memory_interface_dp: LATENCY %0d outside 1..8", LATENCY);
  end

  // Size check first, then range, then alignment.
  function automatic logic [MEM_CODE_W-1:0] req_code(input logic [MEM_COUNT_W-1:0] cnt,
                                                     input logic [1:0]             lo,
                                                     input logic                   in_range);
    logic size_ok;
    logic misaligned;
    size_ok    = 1'b1;
    misaligned = 1'b0;
    case (cnt)
      MEM_COUNT_BYTE: misaligned = 1'b0;
      MEM_COUNT_HALF: misaligned = lo[0];
      MEM_COUNT_WORD: misaligned = (lo != 2'b00);
      default:        size_ok    = 1'b0;
    endcase
    if (!size_ok || !in_range) req_code = MEM_CODE_INVALID;
    else if (misaligned)       req_code = MEM_CODE_MISALIGNED;
    else                       req_code = MEM_CODE_READ;
  endfunction

  function automatic logic [WORD_W-1:0] extract(input logic [WORD_W-1:0]      w,
                                                input logic [MEM_COUNT_W-1:0] cnt,
                                                input logic [1:0]             lo,
                                                input logic                   sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (cnt)
      MEM_COUNT_BYTE: extract = {{24{sext & b[7]}}, b};
      MEM_COUNT_HALF: extract = {{16{sext & h[15]}}, h};
      default:        extract = w;
    endcase
  endfunction

  logic [WORD_W-1:0]     mem [WORD_COUNT];
  logic [IDX_W-1:0]      a_idx, b_idx;
  logic                  a_in_range, b_in_range;
  logic [MEM_CODE_W-1:0] a_code, b_code;
  res_t                  a_res_d, b_res_d;
  logic                  b_we;
  logic [WORD_W-1:0]     b_wr_word;

  assign a_idx = IDX_W'(i_a_req_addr[ADDR_W-1:2] % WORD_COUNT);
  assign b_idx = IDX_W'(i_b_req_addr[ADDR_W-1:2] % WORD_COUNT);

`ifdef MEM_BOUNDS_CHECK_EN
  assign a_in_range = (32'(i_a_req_addr[ADDR_W-1:2]) < WORD_COUNT);
  assign b_in_range = (32'(i_b_req_addr[ADDR_W-1:2]) < WORD_COUNT);
`else
  assign a_in_range = 1'b1;
  assign b_in_range = 1'b1;
`endif

  // Port A: read-only, zero-extended.
  always_comb begin
    a_res_d = RES_IDLE;
    a_code  = req_code(i_a_req_count, i_a_req_addr[1:0], a_in_range);
    if (i_a_req_valid) begin
      a_res_d.valid = 1'b1;
      a_res_d.code  = a_code;
      if (a_code == MEM_CODE_READ)
        a_res_d.data = extract(mem[a_idx], i_a_req_count, i_a_req_addr[1:0], 1'b0);
    end
  end

  // Port B: lane-merged write or extended read.
  always_comb begin
    b_res_d   = RES_IDLE;
    b_we      = 1'b0;
    b_wr_word = mem[b_idx];
    b_code    = req_code(i_b_req_count, i_b_req_addr[1:0], b_in_range);
    if (i_b_req_valid) begin
      b_res_d.valid = 1'b1;
      b_res_d.code  = b_code;
      if (b_code == MEM_CODE_READ && i_b_req_wr_en) begin
        b_we         = 1'b1;
        b_res_d.code = MEM_CODE_WRITE;
        case (i_b_req_count)
          MEM_COUNT_BYTE: b_wr_word[{i_b_req_addr[1:0], 3'b000} +: 8] = i_b_req_wr_data[7:0];
          MEM_COUNT_HALF: begin
            if (i_b_req_addr[1]) b_wr_word[31:16] = i_b_req_wr_data[15:0];
            else                 b_wr_word[15:0]  = i_b_req_wr_data[15:0];
          end
          default:        b_wr_word = i_b_req_wr_data;
        endcase
      end else if (b_code == MEM_CODE_READ) begin
        b_res_d.data = extract(mem[b_idx], i_b_req_count, i_b_req_addr[1:0], ~i_b_req_unsigned);
      end
    end
  end

  // Writes land at the acceptance edge; same-cycle port A reads see the old word.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < WORD_COUNT; i++) mem[IDX_W'(i)] <= '0;
    end else if (b_we) begin
      mem[b_idx] <= b_wr_word;
    end
  end

  res_t a_pipe [LATENCY];
  res_t b_pipe [LATENCY];

  for (genvar s = 0; s < LATENCY; s++) begin : g_stage
    if (s == 0) begin : g_head
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          a_pipe[0] <= RES_IDLE;
          b_pipe[0] <= RES_IDLE;
        end else begin
          a_pipe[0] <= a_res_d;
          b_pipe[0] <= b_res_d;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
          a_pipe[s] <= RES_IDLE;
          b_pipe[s] <= RES_IDLE;
        end else begin
          a_pipe[s] <= a_pipe[s-1];
          b_pipe[s] <= b_pipe[s-1];
        end
      end
    end
  end

  assign o_a_res_valid   = a_pipe[LATENCY-1].valid;
  assign o_a_res_rd_data = a_pipe[LATENCY-1].data;
  assign o_a_res_code    = a_pipe[LATENCY-1].code;
  assign o_b_res_valid   = b_pipe[LATENCY-1].valid;
  assign o_b_res_rd_data = b_pipe[LATENCY-1].data;
  assign o_b_res_code    = b_pipe[LATENCY-1].code;

endmodule

// File: tb/tb_memory_interface_dp.sv
// Bench for memory_interface_dp: directed scenarios plus randomized traffic against a byte-array model.
module tb_memory_interface_dp;

  localparam int unsigned AW  = 12;
  localparam int unsigned WC  = 16;
  localparam int unsigned LAT = 3;

  localparam logic [1:0] N_NONE = 2'd0, N_BYTE = 2'd1, N_HALF = 2'd2, N_WORD = 2'd3;
  localparam logic [1:0] C_INV = 2'd0, C_RD = 2'd1, C_WR = 2'd2, C_MIS = 2'd3;
  localparam logic [34:0] IDLE = {1'b0, 32'h0, C_INV};

  logic          clk;
  logic          aresetn;
  logic          a_v;
  logic [AW-1:0] a_addr;
  logic [1:0]    a_cnt;
  logic          a_res_v;
  logic [31:0]   a_res_d;
  logic [1:0]    a_res_c;
  logic          b_v;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_wd;
  logic          b_we;
  logic [1:0]    b_cnt;
  logic          b_uns;
  logic          b_res_v;
  logic [31:0]   b_res_d;
  logic [1:0]    b_res_c;
  logic [34:0]   a_obs, b_obs;

  int total = 0;
  int bad   = 0;
  logic [7:0] mb [WC*4];

  assign a_obs = {a_res_v, a_res_d, a_res_c};
  assign b_obs = {b_res_v, b_res_d, b_res_c};

  memory_interface_dp #(.ADDR_W(AW), .WORD_COUNT(WC), .LATENCY(LAT)) dut (
    .clk(clk), .aresetn(aresetn),
    .i_a_req_valid(a_v), .i_a_req_addr(a_addr), .i_a_req_count(a_cnt),
    .o_a_res_valid(a_res_v), .o_a_res_rd_data(a_res_d), .o_a_res_code(a_res_c),
    .i_b_req_valid(b_v), .i_b_req_addr(b_addr), .i_b_req_wr_data(b_wd),
    .i_b_req_wr_en(b_we), .i_b_req_count(b_cnt), .i_b_req_unsigned(b_uns),
    .o_b_res_valid(b_res_v), .o_b_res_rd_data(b_res_d), .o_b_res_code(b_res_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [AW-1:0] ad, input logic [1:0] c);
    a_v = v; a_addr = ad; a_cnt = c;
  endtask

  task automatic set_b(input logic v, input logic [AW-1:0] ad, input logic [31:0] wd,
                       input logic we, input logic [1:0] c, input logic uns);
    b_v = v; b_addr = ad; b_wd = wd; b_we = we; b_cnt = c; b_uns = uns;
  endtask

  task automatic idle();
    set_a(1'b0, '0, N_NONE);
    set_b(1'b0, '0, 32'h0, 1'b0, N_NONE, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    aresetn = 1'b0;
    step();
    step();
    aresetn = 1'b1;
    step();
    for (int k = 0; k < int'(WC) * 4; k++) mb[k] = 8'h00;
  endtask

  // Single isolated port-B request; returns the response seen LAT edges later.
  task automatic one_b(input logic [AW-1:0] ad, input logic [31:0] wd, input logic we,
                       input logic [1:0] c, input logic uns, output logic [34:0] r);
    set_b(1'b1, ad, wd, we, c, uns);
    step();
    idle();
    repeat (LAT - 1) step();
    r = b_obs;
  endtask

  task automatic one_a(input logic [AW-1:0] ad, input logic [1:0] c, output logic [34:0] r);
    set_a(1'b1, ad, c);
    step();
    idle();
    repeat (LAT - 1) step();
    r = a_obs;
  endtask

  // Reference: byte-addressed memory, responses from size/range/alignment rules.
  task automatic model(input bit is_b, input logic v, input logic [AW-1:0] ad, input logic [1:0] cnt,
                       input logic we, input logic [31:0] wd, input logic uns, output logic [34:0] r);
    int n, word, base;
    logic [31:0] val;
    r = IDLE;
    if (!v) return;
    n = (cnt == N_BYTE) ? 1 : (cnt == N_HALF) ? 2 : (cnt == N_WORD) ? 4 : 0;
    r = {1'b1, 32'h0, C_INV};
    if (n == 0) return;
    word = int'(ad) / 4;
`ifdef MEM_BOUNDS_CHECK_EN
    if (word >= int'(WC)) return;
`endif
    if (int'(ad) % n != 0) begin
      r = {1'b1, 32'h0, C_MIS};
      return;
    end
    base = (word % int'(WC)) * 4 + int'(ad) % 4;
    if (is_b && we) begin
      for (int j = 0; j < n; j++) mb[base + j] = wd[8*j +: 8];
      r = {1'b1, 32'h0, C_WR};
    end else begin
      val = 32'h0;
      for (int j = 0; j < n; j++) val = val | (32'(mb[base + j]) << (8 * j));
      if (is_b && !uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
      r = {1'b1, val, C_RD};
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    set_a(1'b1, 12'h010, N_WORD);
    set_b(1'b1, 12'h010, 32'h1234_5678, 1'b1, N_WORD, 1'b0);
    repeat (3) step();
    total++;
    if (a_obs !== IDLE) begin bad++; $display("FAIL reset_a got=%h want=%h", a_obs, IDLE); end
    total++;
    if (b_obs !== IDLE) begin bad++; $display("FAIL reset_b got=%h want=%h", b_obs, IDLE); end
    idle();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    set_b(1'b1, 12'h010, 32'hDEAD_BEEF, 1'b1, N_WORD, 1'b0);
    step();
    set_b(1'b0, '0, 32'h0, 1'b0, N_NONE, 1'b0);
    set_a(1'b1, 12'h010, N_WORD);
    step();
    idle();
    repeat (LAT - 2) step();
    total++;
    if (b_obs !== {1'b1, 32'h0, C_WR}) begin bad++; $display("FAIL wr_resp got=%h want=%h", b_obs, {1'b1, 32'h0, C_WR}); end
    total++;
    if (a_obs !== IDLE) begin bad++; $display("FAIL rd_early got=%h want=%h", a_obs, IDLE); end
    step();
    total++;
    if (a_obs !== {1'b1, 32'hDEAD_BEEF, C_RD}) begin bad++; $display("FAIL rd_after_wr got=%h want=%h", a_obs, {1'b1, 32'hDEAD_BEEF, C_RD}); end
    step();
    total++;
    if (a_obs !== IDLE) begin bad++; $display("FAIL rd_held got=%h want=%h", a_obs, IDLE); end
  endtask

  task automatic test_extension();
    logic [34:0] r;
    one_b(12'h013, 32'h0, 1'b0, N_BYTE, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'hFFFF_FFDE, C_RD}) begin bad++; $display("FAIL sext_byte got=%h want=%h", r, {1'b1, 32'hFFFF_FFDE, C_RD}); end
    one_b(12'h013, 32'h0, 1'b0, N_BYTE, 1'b1, r);
    total++;
    if (r !== {1'b1, 32'h0000_00DE, C_RD}) begin bad++; $display("FAIL zext_byte got=%h want=%h", r, {1'b1, 32'h0000_00DE, C_RD}); end
    one_b(12'h012, 32'h0, 1'b0, N_HALF, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'hFFFF_DEAD, C_RD}) begin bad++; $display("FAIL sext_half got=%h want=%h", r, {1'b1, 32'hFFFF_DEAD, C_RD}); end
    one_a(12'h013, N_BYTE, r);
    total++;
    if (r !== {1'b1, 32'h0000_00DE, C_RD}) begin bad++; $display("FAIL a_byte got=%h want=%h", r, {1'b1, 32'h0000_00DE, C_RD}); end
    one_a(12'h010, N_HALF, r);
    total++;
    if (r !== {1'b1, 32'h0000_BEEF, C_RD}) begin bad++; $display("FAIL a_half got=%h want=%h", r, {1'b1, 32'h0000_BEEF, C_RD}); end
  endtask

  task automatic test_half_write();
    logic [34:0] r;
    one_b(12'h012, 32'hAAAA_1234, 1'b1, N_HALF, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h0, C_WR}) begin bad++; $display("FAIL half_wr got=%h want=%h", r, {1'b1, 32'h0, C_WR}); end
    one_b(12'h010, 32'h0, 1'b0, N_WORD, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h1234_BEEF, C_RD}) begin bad++; $display("FAIL half_merge got=%h want=%h", r, {1'b1, 32'h1234_BEEF, C_RD}); end
    one_b(12'h011, 32'h0000_FFFF, 1'b1, N_HALF, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h0, C_MIS}) begin bad++; $display("FAIL half_misalign got=%h want=%h", r, {1'b1, 32'h0, C_MIS}); end
    one_b(12'h010, 32'h5555_5555, 1'b1, N_NONE, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h0, C_INV}) begin bad++; $display("FAIL size_none got=%h want=%h", r, {1'b1, 32'h0, C_INV}); end
    one_b(12'h012, 32'h0, 1'b0, N_WORD, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h0, C_MIS}) begin bad++; $display("FAIL word_misalign got=%h want=%h", r, {1'b1, 32'h0, C_MIS}); end
    one_b(12'h010, 32'h0, 1'b0, N_WORD, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h1234_BEEF, C_RD}) begin bad++; $display("FAIL no_write_on_err got=%h want=%h", r, {1'b1, 32'h1234_BEEF, C_RD}); end
  endtask

  task automatic test_collision();
    set_b(1'b1, 12'h020, 32'h5, 1'b1, N_WORD, 1'b0);
    set_a(1'b1, 12'h020, N_WORD);
    step();
    set_b(1'b0, '0, 32'h0, 1'b0, N_NONE, 1'b0);
    step();
    idle();
    repeat (LAT - 2) step();
    total++;
    if (a_obs !== {1'b1, 32'h0, C_RD}) begin bad++; $display("FAIL coll_old got=%h want=%h", a_obs, {1'b1, 32'h0, C_RD}); end
    step();
    total++;
    if (a_obs !== {1'b1, 32'h5, C_RD}) begin bad++; $display("FAIL coll_new got=%h want=%h", a_obs, {1'b1, 32'h5, C_RD}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4];
    logic [34:0] obs [LAT + 6];
    logic [34:0] exp_r;
    for (int i = 0; i < 4; i++) begin
      vals[i] = $urandom;
      set_b(1'b1, 12'(4 * i), vals[i], 1'b1, N_WORD, 1'b0);
      step();
    end
    idle();
    repeat (LAT) step();
    for (int s = 1; s <= int'(LAT) + 5; s++) begin
      if (s <= 4) set_a(1'b1, 12'(4 * (s - 1)), N_WORD);
      else        idle();
      step();
      obs[s] = a_obs;
    end
    for (int s = 1; s <= int'(LAT) + 5; s++) begin
      exp_r = (s >= int'(LAT) && s < int'(LAT) + 4) ? {1'b1, vals[s - int'(LAT)], C_RD} : IDLE;
      total++;
      if (obs[s] !== exp_r) begin bad++; $display("FAIL b2b step=%0d got=%h want=%h", s, obs[s], exp_r); end
    end
    // Reset with two reads in flight: both must vanish.
    set_a(1'b1, 12'h000, N_WORD);
    step();
    set_a(1'b1, 12'h004, N_WORD);
    step();
    idle();
    #2 aresetn = 1'b0;
    #1;
    total++;
    if (a_obs !== IDLE) begin bad++; $display("FAIL midreset_a got=%h want=%h", a_obs, IDLE); end
    total++;
    if (b_obs !== IDLE) begin bad++; $display("FAIL midreset_b got=%h want=%h", b_obs, IDLE); end
    step();
    step();
    aresetn = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      total++;
      if (a_obs !== IDLE) begin bad++; $display("FAIL post_reset step=%0d got=%h want=%h", s, a_obs, IDLE); end
    end
    for (int k = 0; k < int'(WC) * 4; k++) mb[k] = 8'h00;
  endtask

  task automatic test_bounds();
    logic [34:0] r;
    logic [31:0] wv;
    do_reset();
    wv = $urandom | 32'h1;
    one_b(12'h040, wv, 1'b1, N_WORD, 1'b0, r);
`ifdef MEM_BOUNDS_CHECK_EN
    total++;
    if (r !== {1'b1, 32'h0, C_INV}) begin bad++; $display("FAIL oob_wr got=%h want=%h", r, {1'b1, 32'h0, C_INV}); end
    one_b(12'h000, 32'h0, 1'b0, N_WORD, 1'b0, r);
    total++;
    if (r !== {1'b1, 32'h0, C_RD}) begin bad++; $display("FAIL oob_nowrite got=%h want=%h", r, {1'b1, 32'h0, C_RD}); end
`else
    total++;
    if (r !== {1'b1, 32'h0, C_WR}) begin bad++; $display("FAIL wrap_wr got=%h want=%h", r, {1'b1, 32'h0, C_WR}); end
    one_b(12'h000, 32'h0, 1'b0, N_WORD, 1'b0, r);
    total++;
    if (r !== {1'b1, wv, C_RD}) begin bad++; $display("FAIL wrap_rd got=%h want=%h", r, {1'b1, wv, C_RD}); end
`endif
  endtask

  task automatic test_random();
    logic [34:0] qa [$];
    logic [34:0] qb [$];
    logic [34:0] ea, eb, xa, xb;
    do_reset();
    for (int i = 0; i < 400 + int'(LAT) - 1; i++) begin
      if (i < 400) begin
        set_a(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 127)), 2'($urandom));
        set_b(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 127)), $urandom,
              1'($urandom), 2'($urandom), 1'($urandom));
      end else begin
        idle();
      end
      model(1'b0, a_v, a_addr, a_cnt, 1'b0, 32'h0, 1'b0, ea);
      model(1'b1, b_v, b_addr, b_cnt, b_we, b_wd, b_uns, eb);
      step();
      qa.push_back(ea);
      qb.push_back(eb);
      if (qa.size() == LAT) begin
        xa = qa.pop_front();
        xb = qb.pop_front();
        total++;
        if (a_obs !== xa) begin bad++; $display("FAIL rand_a i=%0d got=%h want=%h", i, a_obs, xa); end
        total++;
        if (b_obs !== xb) begin bad++; $display("FAIL rand_b i=%0d got=%h want=%h", i, b_obs, xb); end
      end
    end
  endtask

  initial begin
    idle();
    aresetn = 1'b0;
    test_reset();
    test_write_read();
    test_extension();
    test_half_write();
    test_collision();
    test_back_to_back();
    test_bounds();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
